// File: rtl/bp_pkt_fifo_if.sv
// BytePipe byte-stream handshake: 8-bit data with valid/ready flow control.
// The master drives data/valid; the slave answers with ready.
interface bp_pkt_fifo_if;
   logic [7:0] data;
   logic       valid;
   logic       ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/bp_pkt_fifo.sv
// Packet-aware BytePipe FIFO: bytes become visible downstream only after their whole
// length-prefixed packet is stored; oversize packets are swallowed and counted.
module bp_pkt_fifo #(
   parameter int unsigned DEPTH     = 50,
   parameter int unsigned DROPCNT_W = 8
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_cg,
   bp_pkt_fifo_if.slave                 bp_in,
   bp_pkt_fifo_if.master                bp_out,
   output logic [$clog2(DEPTH+1)-1:0]   o_n_committed,
   output logic [DROPCNT_W-1:0]         o_n_dropped
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

   typedef enum logic [1:0] {
      ST_HDR,
      ST_PAYLOAD,
      ST_DISCARD
   } state_t;

   state_t         state_q, state_d;
   logic [7:0]     remaining_q, remaining_d;
   logic [8:0]     pkt_size_q, pkt_size_d;
   logic [PW-1:0]  wptr_q, rptr_q;
   logic           full_q;
   logic [CW-1:0]  n_committed_q;
   logic [DROPCNT_W-1:0] n_dropped_q;
   logic [7:0]     mem [DEPTH];

   logic           xfer_in, xfer_out;
   logic           wr_en, commit, drop_inc;
   logic [CW-1:0]  commit_amt;
   logic           hdr_oversize;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // Discarded bytes are never stored, so DISCARD accepts even when storage is full.
   assign bp_in.ready   = (state_q == ST_DISCARD) || !full_q;
   assign bp_out.valid  = (n_committed_q != '0);
   assign bp_out.data   = bp_out.valid ? mem[rptr_q] : 8'h00;
   assign o_n_committed = n_committed_q;
   assign o_n_dropped   = n_dropped_q;

   assign xfer_in      = bp_in.valid && bp_in.ready && i_cg;
   assign xfer_out     = bp_out.valid && bp_out.ready && i_cg;
   assign hdr_oversize = (32'(bp_in.data) + 32'd1) > DEPTH;

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      pkt_size_d  = pkt_size_q;
      wr_en       = 1'b0;
      commit      = 1'b0;
      commit_amt  = CW'(pkt_size_q);
      drop_inc    = 1'b0;
      if (xfer_in) begin
         unique case (state_q)
            ST_HDR: begin
               remaining_d = bp_in.data;
               if (hdr_oversize) begin
                  drop_inc = 1'b1;
                  state_d  = ST_DISCARD;
               end else begin
                  wr_en      = 1'b1;
                  pkt_size_d = {1'b0, bp_in.data} + 9'd1;
                  if (bp_in.data == 8'h00) begin
                     commit     = 1'b1;
                     commit_amt = CW'(1);
                  end else begin
                     state_d = ST_PAYLOAD;
                  end
               end
            end
            ST_PAYLOAD: begin
               wr_en       = 1'b1;
               remaining_d = remaining_q - 8'd1;
               if (remaining_q == 8'd1) begin
                  commit  = 1'b1;
                  state_d = ST_HDR;
               end
            end
            ST_DISCARD: begin
               remaining_d = remaining_q - 8'd1;
               if (remaining_q == 8'd1) state_d = ST_HDR;
            end
            default: state_d = ST_HDR;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q       <= ST_HDR;
         remaining_q   <= '0;
         pkt_size_q    <= '0;
         wptr_q        <= '0;
         rptr_q        <= '0;
         full_q        <= 1'b0;
         n_committed_q <= '0;
         n_dropped_q   <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         pkt_size_q  <= pkt_size_d;
         if (wr_en)    wptr_q <= ptr_inc(wptr_q);
         if (xfer_out) rptr_q <= ptr_inc(rptr_q);
         if (wr_en && !xfer_out && (ptr_inc(wptr_q) == rptr_q)) full_q <= 1'b1;
         else if (xfer_out && !wr_en)                           full_q <= 1'b0;
         // Commit always coincides with the packet's last write, so the byte
         // written this cycle is included in commit_amt.
         n_committed_q <= n_committed_q + (commit ? commit_amt : '0) - CW'(xfer_out);
         if (drop_inc && (n_dropped_q != '1)) n_dropped_q <= n_dropped_q + 1'b1;
      end
   end

   // NOTE: storage has no reset; pointers and counts alone decide what is readable.
   always_ff @(posedge i_clk) begin
      if (wr_en) mem[wptr_q] <= bp_in.data;
   end

endmodule
